// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer: state encoding,
// opcode table, ALU function codes, fault codes and the opcode decode helpers.
package alu_seq_pkg;

    localparam int OPC_BITS = 5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_DONE  = 4'd7,
        S_FAULT = 4'd8
    } state_e;

    localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPC_BITS-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPC_BITS-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPC_BITS-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPC_BITS-1:0] OPC_SHRA = 5'b01000;
    localparam logic [OPC_BITS-1:0] OPC_SHL  = 5'b01001;
    localparam logic [OPC_BITS-1:0] OPC_ROR  = 5'b01010;
    localparam logic [OPC_BITS-1:0] OPC_ROL  = 5'b01011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_BADREG  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    function automatic logic opc_legal(input logic [OPC_BITS-1:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_ROL);
    endfunction

    function automatic logic [3:0] opc_to_aluop(input logic [OPC_BITS-1:0] opc);
        logic [3:0] op;
        case (opc)
            OPC_ADD:  op = ALU_ADD;
            OPC_SUB:  op = ALU_SUB;
            OPC_AND:  op = ALU_AND;
            OPC_OR:   op = ALU_OR;
            OPC_SHR:  op = ALU_SHR;
            OPC_SHRA: op = ALU_SHRA;
            OPC_SHL:  op = ALU_SHL;
            OPC_ROR:  op = ALU_ROR;
            OPC_ROL:  op = ALU_ROL;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-field to one-hot decoder with enable; fields beyond NUM_REGS decode to
// all zeros so an out-of-range register never drives or loads anything.
module reg_onehot_dec #(
    parameter int REG_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                en_i,
    input  logic [REG_W-1:0]    sel_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && (sel_i == REG_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for register-to-register ALU ops.
// All strobes are registered from the next state, so reset clears them asynchronously.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int OPC_W    = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_rdy,
    input  logic [DATA_W-1:0]   ir,
    output logic                busy,
    output logic                done,
    output logic [1:0]          fault_code,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [3:0]          alu_op
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [REG_W:0] NREGS_L = (REG_W+1)'(NUM_REGS);

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] ra, rb, rc;
    logic             unused_ir;

    assign opcode    = ir[DATA_W-1 -: OPC_W];
    assign ra        = ir[DATA_W-OPC_W-1 -: REG_W];
    assign rb        = ir[DATA_W-OPC_W-REG_W-1 -: REG_W];
    assign rc        = ir[DATA_W-OPC_W-2*REG_W-1 -: REG_W];
    assign unused_ir = ^ir[DATA_W-OPC_W-3*REG_W-1:0];

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic              bad_reg, t1_entry;

    assign bad_reg  = ({1'b0, ra} >= NREGS_L) || ({1'b0, rb} >= NREGS_L) ||
                      ({1'b0, rc} >= NREGS_L);
    assign t1_entry = (state_d == S_T1) && (state_q != S_T1);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    state_d = S_T0;
                    wait_d  = '0;
                    fault_d = FC_NONE;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (mem_rdy) begin
                    state_d = S_T2;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_d = S_FAULT;
                        fault_d = FC_TIMEOUT;
                    end
                end
            end
            S_T2: begin
                state_d = S_T3;
                wait_d  = '0;
            end
            // Opcode legality outranks register range when both are wrong.
            S_T3: begin
                if (!opc_legal(opcode)) begin
                    state_d = S_FAULT;
                    fault_d = FC_ILLEGAL;
                end else if (bad_reg) begin
                    state_d = S_FAULT;
                    fault_d = FC_BADREG;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    logic       busy_q, done_q;
    logic       pc_out_q, mar_in_q, inc_pc_q, pc_in_q, read_q, mdr_in_q;
    logic       mdr_out_q, ir_in_q, y_in_q, z_in_q, zlow_out_q;
    logic       rout_en_q, rout_rc_q, rin_en_q;
    logic [3:0] alu_op_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            fault_q    <= FC_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_out_q   <= 1'b0;
            mar_in_q   <= 1'b0;
            inc_pc_q   <= 1'b0;
            pc_in_q    <= 1'b0;
            read_q     <= 1'b0;
            mdr_in_q   <= 1'b0;
            mdr_out_q  <= 1'b0;
            ir_in_q    <= 1'b0;
            y_in_q     <= 1'b0;
            z_in_q     <= 1'b0;
            zlow_out_q <= 1'b0;
            rout_en_q  <= 1'b0;
            rout_rc_q  <= 1'b0;
            rin_en_q   <= 1'b0;
            alu_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            fault_q    <= fault_d;
            busy_q     <= (state_d != S_IDLE) && (state_d != S_FAULT);
            done_q     <= (state_d == S_DONE);
            pc_out_q   <= (state_d == S_T0);
            mar_in_q   <= (state_d == S_T0);
            inc_pc_q   <= (state_d == S_T0);
            pc_in_q    <= t1_entry;
            read_q     <= (state_d == S_T1);
            mdr_in_q   <= (state_d == S_T1);
            mdr_out_q  <= (state_d == S_T2);
            ir_in_q    <= (state_d == S_T2);
            y_in_q     <= (state_d == S_T3);
            z_in_q     <= (state_d == S_T0) || (state_d == S_T4);
            zlow_out_q <= t1_entry || (state_d == S_T5);
            rout_en_q  <= (state_d == S_T3) || (state_d == S_T4);
            rout_rc_q  <= (state_d == S_T4);
            rin_en_q   <= (state_d == S_T5);
            // IR was loaded at the end of T2, so the opcode is stable here.
            alu_op_q   <= (state_d == S_T4) ? opc_to_aluop(opcode) : 4'd0;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fault_code = fault_q;
    assign pc_out     = pc_out_q;
    assign mar_in     = mar_in_q;
    assign inc_pc     = inc_pc_q;
    assign pc_in      = pc_in_q;
    assign read       = read_q;
    assign mdr_in     = mdr_in_q;
    assign mdr_out    = mdr_out_q;
    assign ir_in      = ir_in_q;
    assign y_in       = y_in_q;
    assign z_in       = z_in_q;
    assign zlow_out   = zlow_out_q;
    assign alu_op     = alu_op_q;

    reg_onehot_dec #(.REG_W(REG_W), .NUM_REGS(NUM_REGS)) u_dec_out (
        .en_i     (rout_en_q),
        .sel_i    (rout_rc_q ? rc : rb),
        .onehot_o (reg_out)
    );

    reg_onehot_dec #(.REG_W(REG_W), .NUM_REGS(NUM_REGS)) u_dec_in (
        .en_i     (rin_en_q),
        .sel_i    (ra),
        .onehot_o (reg_in)
    );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: expected per-cycle control words are queued at issue time and
// popped by a monitor on every cycle the main DUT reports busy or done.
module tb_alu_instr_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [1:0]  fc;
        logic [10:0] strb;
        logic [15:0] ro;
        logic [15:0] ri;
        logic [3:0]  op;
    } word_t;

    // strb bits: pc_out mar_in inc_pc pc_in read mdr_in mdr_out ir_in y_in z_in zlow_out
    localparam logic [10:0] W_T0  = 11'b11100000010;
    localparam logic [10:0] W_T1E = 11'b00011100001;
    localparam logic [10:0] W_T1  = 11'b00001100000;
    localparam logic [10:0] W_T2  = 11'b00000011000;
    localparam logic [10:0] W_T3  = 11'b00000000100;
    localparam logic [10:0] W_T4  = 11'b00000000010;
    localparam logic [10:0] W_T5  = 11'b00000000001;

    logic        clk, clr, start, mem_rdy;
    logic [31:0] ir;
    logic        busy, done, pc_out, mar_in, inc_pc, pc_in, read, mdr_in;
    logic        mdr_out, ir_in, y_in, z_in, zlow_out;
    logic [1:0]  fault_code;
    logic [15:0] reg_out, reg_in;
    logic [3:0]  alu_op;

    logic        start2, mem_rdy2;
    logic [31:0] ir2;
    logic        busy2, done2, pc_out2, mar_in2, inc_pc2, pc_in2, read2, mdr_in2;
    logic        mdr_out2, ir_in2, y_in2, z_in2, zlow_out2;
    logic [1:0]  fault_code2;
    logic [11:0] reg_out2, reg_in2;
    logic [3:0]  alu_op2;

    word_t obs;
    assign obs = {busy, done, fault_code, pc_out, mar_in, inc_pc, pc_in, read, mdr_in,
                  mdr_out, ir_in, y_in, z_in, zlow_out, reg_out, reg_in, alu_op};

    alu_instr_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy), .done(done), .fault_code(fault_code),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in), .read(read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlow_out(zlow_out), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op)
    );

    alu_instr_sequencer #(.NUM_REGS(12)) dut12 (
        .clk(clk), .clr(clr), .start(start2), .mem_rdy(mem_rdy2), .ir(ir2),
        .busy(busy2), .done(done2), .fault_code(fault_code2),
        .pc_out(pc_out2), .mar_in(mar_in2), .inc_pc(inc_pc2), .pc_in(pc_in2), .read(read2),
        .mdr_in(mdr_in2), .mdr_out(mdr_out2), .ir_in(ir_in2), .y_in(y_in2), .z_in(z_in2),
        .zlow_out(zlow_out2), .reg_out(reg_out2), .reg_in(reg_in2), .alu_op(alu_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    string tag_q[$];
    int    rin2_cnt = 0;

    always @(negedge clk) begin
        if (|reg_in2) rin2_cnt <= rin2_cnt + 1;
    end

    always @(negedge clk) begin
        word_t e;
        string t;
        if (clr && (busy || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, required no output", obs);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", t, obs, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    function automatic word_t mk_w(input logic b, input logic d, input logic [10:0] s,
                                   input logic [15:0] ro, input logic [15:0] ri,
                                   input logic [3:0] op);
        return '{busy: b, done: d, fc: 2'b00, strb: s, ro: ro, ri: ri, op: op};
    endfunction

    task automatic push(input string t, input word_t w);
        exp_q.push_back(w);
        tag_q.push_back(t);
    endtask

    // kind 0: full instruction, 1: stops after T3, 2: memory timeout after 15 T1 cycles
    task automatic push_instr(input string t, input logic [31:0] irv, input int nwait,
                              input int kind, input logic [3:0] exp_op);
        logic [3:0] ra, rb, rc;
        int n1;
        ra = irv[26:23];
        rb = irv[22:19];
        rc = irv[18:15];
        n1 = (kind == 2) ? 15 : nwait + 1;
        push({t, "_t0"}, mk_w(1, 0, W_T0, 0, 0, 0));
        push({t, "_t1_entry"}, mk_w(1, 0, W_T1E, 0, 0, 0));
        for (int i = 1; i < n1; i++) push({t, "_t1_wait"}, mk_w(1, 0, W_T1, 0, 0, 0));
        if (kind == 2) return;
        push({t, "_t2"}, mk_w(1, 0, W_T2, 0, 0, 0));
        push({t, "_t3"}, mk_w(1, 0, W_T3, 16'd1 << rb, 0, 0));
        if (kind == 1) return;
        push({t, "_t4"}, mk_w(1, 0, W_T4, 16'd1 << rc, 0, exp_op));
        push({t, "_t5"}, mk_w(1, 0, W_T5, 0, 16'd1 << ra, 0));
        push({t, "_done"}, mk_w(1, 1, 11'b0, 0, 0, 0));
    endtask

    // Called just after an active edge; mem_rdy is low for the first nwait T1 cycles.
    task automatic drive(input logic [31:0] irv, input int nwait);
        ir      = irv;
        mem_rdy = (nwait == 0);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        repeat (nwait) @(posedge clk);
        #1 mem_rdy = 1'b1;
    endtask

    task automatic drain(input string t, input int cyc);
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        #1 chk({t, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run2(input logic [31:0] irv, output bit fin);
        ir2    = irv;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 30 && !fin; i++) begin
            @(negedge clk);
            if (fault_code2 != 2'b00 || done2) fin = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fin;
        int c0;
        clr = 1'b0; start = 1'b0; mem_rdy = 1'b0; ir = '0;
        start2 = 1'b0; mem_rdy2 = 1'b1; ir2 = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 64'(obs), 64'd0);
        chk("reset_outputs_dut12", 64'({busy2, done2, fault_code2, reg_in2}), 64'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // rol R6,R6,R4 with memory ready immediately
        push_instr("rol", 32'h5B32_0000, 0, 0, 4'd8);
        drive(32'h5B32_0000, 0);
        drain("rol", 8);
        chk("rol_fault_code", 64'(fault_code), 64'd0);

        // same instruction, three memory wait states
        push_instr("rol_wait3", 32'h5B32_0000, 3, 0, 4'd8);
        drive(32'h5B32_0000, 3);
        drain("rol_wait3", 8);

        // shra R15,R0,R15: highest register numbers
        push_instr("shra_r15", mk_ir(5'b01000, 4'd15, 4'd0, 4'd15), 0, 0, 4'd5);
        drive(mk_ir(5'b01000, 4'd15, 4'd0, 4'd15), 0);
        drain("shra_r15", 8);

        // memory never ready -> timeout fault
        push_instr("timeout", 32'h5B32_0000, 0, 2, 4'd0);
        drive(32'h5B32_0000, 20);
        drain("timeout", 2);
        chk("timeout_fault_code", 64'(fault_code), 64'd3);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_strobes", 64'(obs.strb), 64'd0);

        // restart out of FAULT; T0 word expects fault_code already cleared
        push_instr("sub_after_fault", mk_ir(5'b00100, 4'd3, 4'd1, 4'd2), 0, 0, 4'd1);
        drive(mk_ir(5'b00100, 4'd3, 4'd1, 4'd2), 0);
        drain("sub_after_fault", 8);

        // illegal opcode 11111
        push_instr("illegal", 32'hF800_0000, 0, 1, 4'd0);
        drive(32'hF800_0000, 0);
        drain("illegal", 4);
        chk("illegal_fault_code", 64'(fault_code), 64'd1);
        chk("illegal_busy", 64'(busy), 64'd0);
        chk("illegal_reg_in", 64'(reg_in), 64'd0);

        // start held high: rol then add R1,R2,R3 back to back
        push_instr("b2b_first", 32'h5B32_0000, 0, 0, 4'd8);
        push_instr("b2b_second", mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 0, 0, 4'd0);
        ir = 32'h5B32_0000; mem_rdy = 1'b1; start = 1'b1;
        repeat (8) @(posedge clk);
        #1 start = 1'b0;
        ir = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        drain("b2b", 10);

        // reset asserted during T4
        push_instr("reset_t4", 32'h5B32_0000, 0, 1, 4'd0);
        drive(32'h5B32_0000, 0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        #1 chk("reset_t4_outputs", 64'(obs), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("reset_t4_held", 64'(obs), 64'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        push_instr("after_reset", 32'h5B32_0000, 0, 0, 4'd8);
        drive(32'h5B32_0000, 0);
        drain("after_reset", 8);

        // NUM_REGS=12 instance: Ra=13 is out of range
        c0 = rin2_cnt;
        run2(mk_ir(5'b01011, 4'd13, 4'd2, 4'd3), fin);
        chk("badreg_finished", 64'(fin), 64'd1);
        chk("badreg_fault_code", 64'(fault_code2), 64'd2);
        chk("badreg_busy", 64'(busy2), 64'd0);
        chk("badreg_no_reg_in", 64'(rin2_cnt - c0), 64'd0);

        // illegal opcode outranks bad register
        run2(mk_ir(5'b11111, 4'd13, 4'd2, 4'd3), fin);
        chk("priority_finished", 64'(fin), 64'd1);
        chk("priority_fault_code", 64'(fault_code2), 64'd1);

        // R11 is the last legal register with 12 registers
        c0 = rin2_cnt;
        run2(mk_ir(5'b00011, 4'd11, 4'd11, 4'd11), fin);
        chk("r11_finished", 64'(fin), 64'd1);
        chk("r11_done", 64'(done2), 64'd1);
        chk("r11_fault_code", 64'(fault_code2), 64'd0);
        chk("r11_reg_in_pulses", 64'(rin2_cnt - c0), 64'd1);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Parametrised multi-cycle control unit that generates the per-step datapath control strobes for register-to-register ALU instructions (fetch, decode, execute, writeback).
- Replaces hand-sequenced T0–T5 stimulus with hardware; drives the existing Datapath control inputs.
- Generalises beyond a single rotate op: full ALU opcode set, parametrised register count, start/done handshake, memory wait states, fault reporting.

Parameters:
- DATA_W, 32, IR/datapath width.
- NUM_REGS, 16, general registers; one-hot width of reg_out/reg_in.
- REG_W, 4, register field width in IR.
- OPC_W, 5, opcode field width.
- MAX_WAIT, 15, max T1 cycles waiting on mem_rdy before timeout fault.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  begin one instruction cycle.
- mem_rdy  in  1  memory read data valid.
- ir  in  DATA_W  current IR contents from datapath.
- busy  out  1  high in any state except IDLE/FAULT.
- done  out  1  one-cycle pulse after writeback.
- fault_code  out  2  00 none, 01 illegal opcode, 10 bad register, 11 memory timeout; sticky.
- pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out  out  1 each  datapath strobes.
- reg_out  out  NUM_REGS  one-hot register bus drive.
- reg_in  out  NUM_REGS  one-hot register load.
- alu_op  out  4  ALU function select.

Behaviour:
- Reset (clr=0, async): state=IDLE; every output 0, fault_code=00, wait counter 0, all taking effect immediately.
- Moore outputs decoded from registered state; at most one bus driver asserted per cycle.
- IR fields: opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- IDLE: start=1 -> T0, fault_code cleared to 00. start=0 -> stay.
- T0 (1 cycle): pc_out, mar_in, inc_pc, z_in.
- T1: on the entry cycle only, zlow_out and pc_in. Every T1 cycle: read, mdr_in. Wait counter increments each cycle mem_rdy=0.
  - mem_rdy=1 -> T2.
  - Counter reaches MAX_WAIT with mem_rdy=0 -> FAULT, code 11.
- T2: mdr_out, ir_in; counter cleared. -> T3.
- T3: checks, in priority order:
  - opcode not in package table -> FAULT, code 01.
  - any of Ra/Rb/Rc >= NUM_REGS -> FAULT, code 10.
  - otherwise reg_out[Rb], y_in -> T4.
- T4: reg_out[Rc], z_in, alu_op=decoded op -> T5.
- T5: zlow_out, reg_in[Ra] -> DONE.
- DONE: done=1, no strobes.
  - start=1 -> T0 (back-to-back, no idle cycle).
  - start=0 -> IDLE.
- FAULT: all strobes 0, busy=0, fault_code held. start=1 -> T0 with fault_code cleared.
- start ignored while busy.
- Ra==Rb (e.g. rol R6,R6,R4) is legal: Rb is read in T3, Ra is written in T5.
- Reset mid-instruction: immediate return to IDLE; no partial reg_in pulse.
- Unused state encodings recover to IDLE.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum: IDLE, T0–T5, DONE, FAULT.
  - opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011.
  - alu_op constants: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8.
  - fault code constants.
  - opcode-to-alu_op decode function.
- One sub-module, reg_onehot_dec (REG_W -> NUM_REGS decoder with enable), instantiated twice for reg_out/reg_in.

Test Plan:
- Reset, start=1, ir=0x5B320000 (rol R6,R6,R4), mem_rdy=1 always -> T0–T5 take 6 cycles, reg_out[6] in T3, reg_out[4]+alu_op=8 in T4, reg_in[6] in T5, done at cycle 7, fault_code=00.
- Same instruction, mem_rdy low 3 cycles -> T1 lasts 4 cycles; pc_in only on first T1 cycle; read/mdr_in held all 4; total 10 cycles to done.
- mem_rdy never asserted -> FAULT after MAX_WAIT=15 T1 cycles, fault_code=11, busy=0; then start -> T0, fault_code=00.
- ir opcode 11111 -> FAULT at T3 exit, code 01, no reg_in pulse. With NUM_REGS=12, Ra=13 -> code 10.
- start held high, two instructions -> DONE followed directly by T0; done pulses exactly once per instruction.
- clr driven low during T4 -> all outputs 0 within the same time step, state IDLE; release and restart completes normally.
